hazard_unit: RTL and testbench

Pipeline hazard controller for the 16-bit, 16-register CPU. It decodes the instruction in the decode stage against a three-slot in-flight scoreboard (E, M, W) and drives the controls that the execute-stage pipeline register consumes:
- `flushC` to insert a bubble,
- `stallF`/`stallD` to hold fetch and decode,
- `flushD` on a taken branch,
- registered forwarding selects for the execute stage.

It also keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_unit_if.sv | 32 +++
 rtl/hazard_unit.sv | 92 +++++++++
 tb/tb_hazard_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Decode-stage hazard bus: decode instruction fields in, pipeline control and
// forwarding selects out. The pipeline drives as master, hazard_unit is the slave.
interface hazard_unit_if;
  logic        validD;
  logic [3:0]  srcAddD1;
  logic [3:0]  srcAddD2;
  logic        srcUseD1;
  logic        srcUseD2;
  logic [3:0]  destAddD;
  logic        RegWriteC;
  logic        MemToRegC;
  logic        branchTakenE;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        flushC;
  logic [1:0]  fwdSelE1;
  logic [1:0]  fwdSelE2;
  logic [15:0] stallCount;

  modport master (
    output validD, srcAddD1, srcAddD2, srcUseD1, srcUseD2, destAddD,
           RegWriteC, MemToRegC, branchTakenE,
    input  stallF, stallD, flushD, flushC, fwdSelE1, fwdSelE2, stallCount
  );

  modport slave (
    input  validD, srcAddD1, srcAddD2, srcUseD1, srcUseD2, destAddD,
           RegWriteC, MemToRegC, branchTakenE,
    output stallF, stallD, flushD, flushC, fwdSelE1, fwdSelE2, stallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: E/M/W in-flight scoreboard, load-use stall,
// branch flush, registered forwarding selects and a saturating stall counter.
module hazard_unit #(
  parameter int LOAD_LAT      = 1,
  parameter bit ZERO_REG_HARD = 1'b1
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       m2r;
    logic [3:0] dst;
  } slot_t;

  // A load stays hazardous while it sits in any slot inside the load window.
  localparam bit WIN_M = (LOAD_LAT >= 2);
  localparam bit WIN_W = (LOAD_LAT >= 3);

  slot_t       slotE, slotM, slotW;
  logic [1:0]  fwdSel1, fwdSel2;
  logic [15:0] stallCnt;

  logic hitE1, hitE2, hitM1, hitM2, hitW1, hitW2;
  logic lu, stall, issue;

  function automatic logic srcMatch(input slot_t s, input logic [3:0] addr,
                                    input logic used);
    return s.v && s.rw && (s.dst == addr) && used &&
           !(ZERO_REG_HARD && (addr == 4'd0));
  endfunction

  // Nearest producer wins; a load still in E cannot forward its ALU result.
  function automatic logic [1:0] pickFwd(input logic hitE, input logic eIsLoad,
                                         input logic hitM);
    if (hitE && !eIsLoad) return 2'b01;
    if (hitM)             return 2'b10;
    return 2'b00;
  endfunction

  assign hitE1 = srcMatch(slotE, hz.srcAddD1, hz.srcUseD1);
  assign hitE2 = srcMatch(slotE, hz.srcAddD2, hz.srcUseD2);
  assign hitM1 = srcMatch(slotM, hz.srcAddD1, hz.srcUseD1);
  assign hitM2 = srcMatch(slotM, hz.srcAddD2, hz.srcUseD2);
  assign hitW1 = srcMatch(slotW, hz.srcAddD1, hz.srcUseD1);
  assign hitW2 = srcMatch(slotW, hz.srcAddD2, hz.srcUseD2);

  assign lu = (slotE.m2r && (hitE1 || hitE2))
           || (WIN_M && slotM.m2r && (hitM1 || hitM2))
           || (WIN_W && slotW.m2r && (hitW1 || hitW2));

  // A taken branch squashes the decode instruction, so it never stalls.
  assign stall = hz.validD && lu && !hz.branchTakenE;
  assign issue = hz.validD && !stall && !hz.branchTakenE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: whole slots are cleared, not just v, so no X ever reaches the comparators.
      slotE    <= '0;
      slotM    <= '0;
      slotW    <= '0;
      fwdSel1  <= 2'b00;
      fwdSel2  <= 2'b00;
      stallCnt <= '0;
    end else begin
      slotW <= slotM;
      slotM <= slotE;
      if (issue) begin
        slotE   <= '{v: 1'b1, rw: hz.RegWriteC, m2r: hz.MemToRegC, dst: hz.destAddD};
        fwdSel1 <= pickFwd(hitE1, slotE.m2r, hitM1);
        fwdSel2 <= pickFwd(hitE2, slotE.m2r, hitM2);
      end else begin
        slotE   <= '0;
        fwdSel1 <= 2'b00;
        fwdSel2 <= 2'b00;
      end
      if (stall && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
    end
  end

  assign hz.stallF     = stall;
  assign hz.stallD     = stall;
  assign hz.flushC     = stall || hz.branchTakenE;
  assign hz.flushD     = hz.branchTakenE;
  assign hz.fwdSelE1   = fwdSel1;
  assign hz.fwdSelE2   = fwdSel2;
  assign hz.stallCount = stallCnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three configurations share one stimulus stream and are
// compared every cycle against an issue-history model, plus directed corner cases.
module tb_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic       u1;
    logic [3:0] s2;
    logic       u2;
    logic [3:0] dst;
    logic       rw;
    logic       m2r;
    logic       br;
  } instr_t;

  // One issued instruction; age 1 = one cycle since issue (execute), 2 = memory, 3 = writeback.
  typedef struct {
    int         dut;
    int         age;
    logic       rw;
    logic       m2r;
    logic [3:0] dst;
  } rec_t;

  logic   clk = 1'b0;
  logic   reset;
  instr_t cur;

  always #5 clk = ~clk;

  hazard_unit_if h0 ();
  hazard_unit_if h1 ();
  hazard_unit_if h2 ();

  hazard_unit #(.LOAD_LAT(1), .ZERO_REG_HARD(1'b1)) dut0 (.clk(clk), .reset(reset), .hz(h0));
  hazard_unit #(.LOAD_LAT(3), .ZERO_REG_HARD(1'b1)) dut1 (.clk(clk), .reset(reset), .hz(h1));
  hazard_unit #(.LOAD_LAT(2), .ZERO_REG_HARD(1'b0)) dut2 (.clk(clk), .reset(reset), .hz(h2));

  assign h0.validD = cur.v;  assign h0.srcAddD1 = cur.s1; assign h0.srcUseD1 = cur.u1;
  assign h0.srcAddD2 = cur.s2; assign h0.srcUseD2 = cur.u2; assign h0.destAddD = cur.dst;
  assign h0.RegWriteC = cur.rw; assign h0.MemToRegC = cur.m2r; assign h0.branchTakenE = cur.br;
  assign h1.validD = cur.v;  assign h1.srcAddD1 = cur.s1; assign h1.srcUseD1 = cur.u1;
  assign h1.srcAddD2 = cur.s2; assign h1.srcUseD2 = cur.u2; assign h1.destAddD = cur.dst;
  assign h1.RegWriteC = cur.rw; assign h1.MemToRegC = cur.m2r; assign h1.branchTakenE = cur.br;
  assign h2.validD = cur.v;  assign h2.srcAddD1 = cur.s1; assign h2.srcUseD1 = cur.u1;
  assign h2.srcAddD2 = cur.s2; assign h2.srcUseD2 = cur.u2; assign h2.destAddD = cur.dst;
  assign h2.RegWriteC = cur.rw; assign h2.MemToRegC = cur.m2r; assign h2.branchTakenE = cur.br;

  logic [3:0]  ctlW [3];
  logic [3:0]  fwW  [3];
  logic [15:0] cntW [3];

  assign ctlW[0] = {h0.stallF, h0.stallD, h0.flushC, h0.flushD};
  assign ctlW[1] = {h1.stallF, h1.stallD, h1.flushC, h1.flushD};
  assign ctlW[2] = {h2.stallF, h2.stallD, h2.flushC, h2.flushD};
  assign fwW[0]  = {h0.fwdSelE1, h0.fwdSelE2};
  assign fwW[1]  = {h1.fwdSelE1, h1.fwdSelE2};
  assign fwW[2]  = {h2.fwdSelE1, h2.fwdSelE2};
  assign cntW[0] = h0.stallCount;
  assign cntW[1] = h1.stallCount;
  assign cntW[2] = h2.stallCount;

  int    latOf [3] = '{1, 3, 2};
  bit    zrhOf [3] = '{1'b1, 1'b1, 1'b0};
  string tagCtl[3] = '{"d0_ctl", "d1_ctl", "d2_ctl"};
  string tagFwd[3] = '{"d0_fwd", "d1_fwd", "d2_fwd"};
  string tagCnt[3] = '{"d0_cnt", "d1_cnt", "d2_cnt"};

  rec_t       flight[$];
  logic [1:0] mFwd1 [3];
  logic [1:0] mFwd2 [3];
  int         mCnt  [3];
  bit         stallNow [3];
  logic [3:0] lastCtl  [3];
  int         rawStalls1;
  int         nChecks = 0;
  int         nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit srcHit(input rec_t r, input logic [3:0] a, input logic u, input int d);
    return r.rw && u && (r.dst == a) && !(zrhOf[d] && (a == 4'd0));
  endfunction

  function automatic bit expStall(input int d, input instr_t in);
    bit lu = 1'b0;
    foreach (flight[i])
      if (flight[i].dut == d && flight[i].m2r && flight[i].age <= latOf[d] &&
          (srcHit(flight[i], in.s1, in.u1, d) || srcHit(flight[i], in.s2, in.u2, d)))
        lu = 1'b1;
    return in.v && lu && !in.br;
  endfunction

  function automatic logic [1:0] expFwd(input int d, input logic [3:0] a, input logic u);
    bit fromE = 1'b0;
    bit fromM = 1'b0;
    foreach (flight[i])
      if (flight[i].dut == d && srcHit(flight[i], a, u, d)) begin
        if (flight[i].age == 1 && !flight[i].m2r) fromE = 1'b1;
        if (flight[i].age == 2) fromM = 1'b1;
      end
    return fromE ? 2'b01 : (fromM ? 2'b10 : 2'b00);
  endfunction

  function automatic instr_t mk(input logic v, input logic [3:0] s1, input logic u1,
                                input logic [3:0] s2, input logic u2, input logic [3:0] dst,
                                input logic rw, input logic m2r, input logic br);
    instr_t t;
    t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2;
    t.dst = dst; t.rw = rw; t.m2r = m2r; t.br = br;
    return t;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    t.v   = ($urandom_range(0, 9) < 8);
    t.s1  = 4'($urandom_range(0, 3));
    t.u1  = 1'($urandom_range(0, 1));
    t.s2  = 4'($urandom_range(0, 3));
    t.u2  = 1'($urandom_range(0, 1));
    t.dst = 4'($urandom_range(0, 3));
    t.rw  = ($urandom_range(0, 3) != 0);
    t.m2r = 1'($urandom_range(0, 1));
    t.br  = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  // Drive one decode cycle, check all three units mid-cycle, then advance the model at the edge.
  task automatic cycle(input instr_t in, input logic rstv);
    bit         issue [3];
    logic [1:0] nf1   [3];
    logic [1:0] nf2   [3];
    cur   = in;
    reset = rstv;
    #3;
    for (int d = 0; d < 3; d++) begin
      stallNow[d] = expStall(d, in);
      check(tagCtl[d], ctlW[d], {stallNow[d], stallNow[d], stallNow[d] | in.br, in.br});
      check(tagFwd[d], fwW[d], {mFwd1[d], mFwd2[d]});
      check(tagCnt[d], cntW[d], mCnt[d]);
      lastCtl[d] = ctlW[d];
      issue[d] = in.v && !stallNow[d] && !in.br;
      nf1[d]   = issue[d] ? expFwd(d, in.s1, in.u1) : 2'b00;
      nf2[d]   = issue[d] ? expFwd(d, in.s2, in.u2) : 2'b00;
    end
    @(posedge clk);
    if (!rstv) begin
      flight.delete();
      for (int d = 0; d < 3; d++) begin
        mFwd1[d] = 2'b00; mFwd2[d] = 2'b00; mCnt[d] = 0;
      end
    end else begin
      foreach (flight[i]) flight[i].age = flight[i].age + 1;
      for (int i = flight.size() - 1; i >= 0; i--)
        if (flight[i].age > 3) flight.delete(i);
      for (int d = 0; d < 3; d++) begin
        mFwd1[d] = nf1[d];
        mFwd2[d] = nf2[d];
        if (stallNow[d] && mCnt[d] < 65535) mCnt[d]++;
        if (stallNow[d] && d == 1) rawStalls1++;
        if (issue[d]) flight.push_back('{d, 1, in.rw, in.m2r, in.dst});
      end
    end
    #1;
  endtask

  instr_t IDLE, ld5, use5, ld0, use0, z5;

  initial begin
    IDLE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ld5  = mk(1, 4'd9, 0, 4'd9, 0, 4'd5, 1, 1, 0);
    use5 = mk(1, 4'd5, 1, 4'd8, 0, 4'd6, 1, 0, 0);
    ld0  = mk(1, 4'd9, 0, 4'd9, 0, 4'd0, 1, 1, 0);
    use0 = mk(1, 4'd0, 1, 4'd8, 0, 4'd7, 1, 0, 0);
    z5   = mk(1, 4'd5, 1, 4'd8, 0, 4'd5, 1, 1, 0);
    for (int d = 0; d < 3; d++) begin
      mFwd1[d] = 2'b00; mFwd2[d] = 2'b00; mCnt[d] = 0;
    end
    rawStalls1 = 0;
    cur   = IDLE;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a valid decode instruction present.
    cycle(use5, 1'b0);
    cycle(use5, 1'b0);
    check("reset_ctl", lastCtl[0], 4'b0000);
    check("reset_cnt", cntW[0], 16'd0);
    check("reset_fwd", fwW[0], 4'b0000);

    // ALU to ALU: producer r3, then src1 = r3, then src2 = r3.
    cycle(mk(1, 4'd9, 0, 4'd9, 0, 4'd3, 1, 0, 0), 1'b1);
    cycle(mk(1, 4'd3, 1, 4'd9, 0, 4'd7, 0, 0, 0), 1'b1);
    check("alu_nostall", lastCtl[0], 4'b0000);
    check("alu_fwd1_e", fwW[0][3:2], 2'b01);
    check("alu_fwd1_e_lat3", fwW[1][3:2], 2'b01);
    cycle(mk(1, 4'd9, 0, 4'd3, 1, 4'd8, 0, 0, 0), 1'b1);
    check("alu_fwd2_m", fwW[0][1:0], 2'b10);
    cycle(IDLE, 1'b1);

    // Load-use: consumer held in decode until it issues in every configuration.
    cycle(IDLE, 1'b0);
    cycle(ld5, 1'b1);
    cycle(use5, 1'b1);
    check("lu1_stall", lastCtl[0], 4'b1110);
    cycle(use5, 1'b1);
    check("lu1_release", lastCtl[0], 4'b0000);
    check("lu1_fwd", fwW[0][3:2], 2'b10);
    check("lu1_count", cntW[0], 16'd1);
    cycle(use5, 1'b1);
    cycle(use5, 1'b1);
    check("lu3_release", lastCtl[1], 4'b0000);
    check("lu3_count", cntW[1], 16'd3);
    check("lu2_count", cntW[2], 16'd2);
    cycle(IDLE, 1'b1);

    // Taken branch in the same cycle as a load-use match.
    cycle(IDLE, 1'b0);
    cycle(ld5, 1'b1);
    cycle(mk(1, 4'd5, 1, 4'd8, 0, 4'd6, 1, 0, 1), 1'b1);
    check("br_ctl", lastCtl[0], 4'b0011);
    check("br_ctl_lat3", lastCtl[1], 4'b0011);
    check("br_count", cntW[0], 16'd0);
    cycle(mk(1, 4'd6, 1, 4'd8, 0, 4'd7, 0, 0, 0), 1'b1);
    check("br_bubble_fwd", fwW[0][3:2], 2'b00);
    check("br_bubble_fwd_lat3", fwW[1][3:2], 2'b00);
    cycle(IDLE, 1'b1);

    // Register 0: hard-zero configurations ignore it, the soft one stalls.
    cycle(IDLE, 1'b0);
    cycle(ld0, 1'b1);
    cycle(use0, 1'b1);
    check("zero_nostall", lastCtl[0], 4'b0000);
    check("zero_soft_stall", lastCtl[2], 4'b1110);
    check("zero_fwd", fwW[0], 4'b0000);
    cycle(IDLE, 1'b1);
    cycle(IDLE, 1'b1);

    // Reset asserted mid-stall drops the stall after the edge.
    cycle(IDLE, 1'b0);
    cycle(ld5, 1'b1);
    cycle(use5, 1'b1);
    cycle(use5, 1'b0);
    check("rst_midstall_hold", lastCtl[1], 4'b1110);
    cycle(use5, 1'b1);
    check("rst_midstall_drop", lastCtl[1], 4'b0000);

    for (int n = 0; n < 800; n++)
      cycle(randInstr(), ($urandom_range(0, 99) != 0));

    // Saturation: a self-dependent load chain keeps the LOAD_LAT=3 unit stalling.
    cycle(IDLE, 1'b0);
    rawStalls1 = 0;
    for (int n = 0; n < 90000 && rawStalls1 < 65540; n++)
      cycle(z5, 1'b1);
    check("sat_budget", (rawStalls1 >= 65540), 1);
    check("sat_count", cntW[1], 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
